// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream and writes
// it into instruction memory. The core is held in reset until the image is complete.
module imem_boot_loader #(
  parameter int unsigned NENTRIES  = 128,
  parameter int unsigned BASE_WORD = 0,
  parameter int unsigned WORD_ADDR = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic        imem_wr_en_o,
  output logic        imem_rd_en_o,
  output logic        core_rst_no,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLen   = 3'd1;
  localparam logic [2:0] StEval  = 3'd2;  // length header complete, check it
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic        accept;
  logic [31:0] word_idx;
  logic [31:0] next_addr;
  logic [32:0] len_end;

  assign accept    = rx_valid_i && rx_ready_o;
  assign word_idx  = 32'(BASE_WORD) + idx_q;
  assign next_addr = (WORD_ADDR != 0) ? word_idx : {word_idx[29:0], 2'b00};
  // 33-bit sum so a huge header cannot wrap past the depth check
  assign len_end   = 33'(BASE_WORD) + {1'b0, len_q};

  // Next-state logic for the load sequence
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    buf_d   = buf_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StLen;
          len_d   = '0;
          buf_d   = '0;
          bcnt_d  = '0;
          idx_d   = '0;
        end
      end
      StLen: begin
        if (accept) begin
          len_d[{bcnt_q, 3'b000} +: 8] = rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = StEval;
        end
      end
      StEval: begin
        if (len_q == 32'd0) begin
          state_d = StDone;
        end else if (len_end > 33'(NENTRIES)) begin
          state_d = StErr;
        end else begin
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          buf_d[{bcnt_q, 3'b000} +: 8] = rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            data_d  = {rx_data_i, buf_q[23:0]};
            addr_d  = next_addr;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        idx_d   = idx_q + 32'd1;
        state_d = (idx_q + 32'd1 == len_q) ? StDone : StData;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      len_q   <= '0;
      buf_q   <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign rx_ready_o   = (state_q == StLen) || (state_q == StData);
  assign imem_wr_en_o = (state_q == StWrite);
  assign imem_addr_o  = addr_q;
  assign imem_data_o  = data_q;
  assign done_o       = (state_q == StDone);
  assign core_rst_no  = (state_q == StDone);
  assign imem_rd_en_o = (state_q == StDone);
  assign err_o        = (state_q == StErr);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: two loaders (word-address base 0, byte-address base 4) share
// one byte stream; writes are scoreboarded against a word-list model of the image.
module tb_imem_boot_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic        a_ready, a_wr, a_rd, a_core, a_done, a_err;
  logic [31:0] a_addr, a_data;
  logic        b_ready, b_wr, b_rd, b_core, b_done, b_err;
  logic [31:0] b_addr, b_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr = -1;
  logic done_prev = 1'b0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] words[$];

  always #5 clk = ~clk;

  imem_boot_loader #(.NENTRIES(128), .BASE_WORD(0), .WORD_ADDR(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(a_ready), .imem_addr_o(a_addr), .imem_data_o(a_data), .imem_wr_en_o(a_wr),
    .imem_rd_en_o(a_rd), .core_rst_no(a_core), .done_o(a_done), .err_o(a_err)
  );

  imem_boot_loader #(.NENTRIES(128), .BASE_WORD(4), .WORD_ADDR(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(b_ready), .imem_addr_o(b_addr), .imem_data_o(b_data), .imem_wr_en_o(b_wr),
    .imem_rd_en_o(b_rd), .core_rst_no(b_core), .done_o(b_done), .err_o(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (a_wr) begin
      q0.push_back({a_addr, a_data});
      last_wr = cyc;
      chk("wr_ready_low", {63'd0, a_ready}, 64'd0);
    end
    if (b_wr) q1.push_back({b_addr, b_data});
    if (a_done && !done_prev && last_wr >= 0) chk("done_after_wr", 64'(cyc), 64'(last_wr + 1));
    done_prev <= a_done;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (a_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rx_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_ctl_a", {58'd0, a_ready, a_wr, a_rd, a_core, a_done, a_err}, 64'd0);
    chk("rst_addr_a", {32'd0, a_addr}, 64'd0);
    chk("rst_data_a", {32'd0, a_data}, 64'd0);
    chk("rst_ctl_b", {58'd0, b_ready, b_wr, b_rd, b_core, b_done, b_err}, 64'd0);
    chk("rst_addr_b", {32'd0, b_addr}, 64'd0);
  endtask

  task automatic fill_rand(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom());
  endtask

  // Full load of n words from 'words'; expectations derived from header value alone
  task automatic do_load(input logic [31:0] n, input bit gaps);
    longint unsigned nn = 64'(n);
    bit e0 = (nn > 128);
    bit e1 = (nn + 4 > 128);
    int exp0, exp1;
    bit ended = 1'b0;
    q0.delete();
    q1.delete();
    last_wr = -1;
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gaps);
    if (!e0) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], gaps);
      end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((a_done || a_err) && (b_done || b_err)) begin ended = 1'b1; break; end
    end
    if (!ended) chk("end_timeout", 64'd0, 64'd1);
    chk("done_a", {63'd0, a_done}, {63'd0, !e0});
    chk("err_a", {63'd0, a_err}, {63'd0, e0});
    chk("core_a", {62'd0, a_core, a_rd}, {62'd0, !e0, !e0});
    chk("done_b", {63'd0, b_done}, {63'd0, !e1});
    chk("err_b", {63'd0, b_err}, {63'd0, e1});
    chk("core_b", {62'd0, b_core, b_rd}, {62'd0, !e1, !e1});
    exp0 = e0 ? 0 : int'(n);
    exp1 = e1 ? 0 : int'(n);
    chk("nwr_a", 64'(q0.size()), 64'(exp0));
    chk("nwr_b", 64'(q1.size()), 64'(exp1));
    for (int i = 0; i < exp0 && i < q0.size(); i++)
      chk("wr_a", q0[i], {32'(i), words[i]});
    for (int i = 0; i < exp1 && i < q1.size(); i++)
      chk("wr_b", q1[i], {32'((4 + i) * 4), words[i]});
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Directed two-word image
    words.delete();
    words.push_back(32'h00100513);
    words.push_back(32'h00200593);
    do_load(32'd2, 1'b0);

    // Header overflow, then recovery with a single word
    do_load(32'd129, 1'b0);
    do_load(32'hFFFF_FFFF, 1'b0);
    fill_rand(1);
    do_load(32'd1, 1'b0);

    // Empty image
    do_load(32'd0, 1'b0);

    // Depth boundary: 124 fits both; 125 only fits base 0
    fill_rand(125);
    do_load(32'd124, 1'b0);
    do_load(32'd125, 1'b0);

    // Random images with valid gaps
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 6);
      fill_rand(n);
      do_load(32'(n), 1'b1);
    end

    // Reset after the first of three words
    fill_rand(3);
    q0.delete();
    q1.delete();
    last_wr = -1;
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(8'(3 >> (8 * k)), 1'b0);
    for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 1'b0);
    send_byte(words[1][7:0], 1'b0);
    send_byte(words[1][15:8], 1'b0);
    chk("mid_nwr", 64'(q0.size()), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_valid = 1'b1;
    rx_data  = words[1][23:16];
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_ready", {63'd0, a_ready}, 64'd0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("post_rst_nwr", 64'(q0.size() + q1.size()), 64'd2);
    chk("post_rst_core", {63'd0, a_core}, 64'd0);

    // Fresh load after the reset
    fill_rand(3);
    do_load(32'd3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
